mult_div_unit: RTL and testbench
================================

Name: mult_div_unit

Overview:
- Multi-cycle integer multiply/divide unit for the MIPS execute stage.
- Operands come directly from the register file read ports (readData1 into srcA, readData2 into srcB).
- Results go into dedicated HI/LO registers. MFHI/MFLO read them out, and the result is written back into the register file.
- Implements MULT, MULTU, DIV, DIVU, MTHI and MTLO with a busy/done handshake to the pipeline control.

Parameters:
- WIDTH, 32, operand width. HI and LO are each WIDTH bits. One iteration is performed per operand bit.

Ports:
- Clk  input  1  system clock; all state updates on posedge.
- Reset  input  1  asynchronous, active-high reset.
- start  input  1  request strobe, sampled on posedge. Accepted only when busy=0.
- op  input  3  0=MULT, 1=MULTU, 2=DIV, 3=DIVU, 4=MTHI, 5=MTLO; 6-7 reserved, ignored.
- srcA  input  WIDTH  multiplicand / dividend / MTHI-MTLO data.
- srcB  input  WIDTH  multiplier / divisor.
- busy  output  1  high while an arithmetic operation is in flight.
- done  output  1  one-cycle pulse when HI/LO have just been updated by an arithmetic operation.
- hi  output  WIDTH  HI register (product upper word / remainder).
- lo  output  WIDTH  LO register (product lower word / quotient).

Behaviour:
- Clock and reset: one clock, Clk. Reset is asynchronous and active-high. Reset asserted forces state=IDLE, busy=0, done=0, hi=0, lo=0 and iteration counter=0 immediately, regardless of Clk.
- States:
  - IDLE: waits for an accepted start.
  - RUN: performs WIDTH iterations.
  - FIX: applies sign correction and commits HI/LO.
- IDLE transitions:
  - start=1 with op 0-3 at edge E0: latch srcA/srcB and op, take absolute values for signed ops (MULT/DIV), record result signs, go to RUN. busy=1 from E0.
  - start=1 with op 4 (MTHI): hi<=srcA at E0. Stay IDLE, no busy, no done.
  - start=1 with op 5 (MTLO): lo<=srcA at E0. Stay IDLE, no busy, no done.
  - op 6-7: no effect.
- RUN: edges E1..E(WIDTH) each perform one iteration.
  - Multiply: shift-add, unsigned, 2*WIDTH-bit accumulator.
  - Divide: restoring shift-subtract, unsigned.
  - After E(WIDTH), go to FIX.
- FIX at E(WIDTH+1):
  - Signed multiply: negate the 2*WIDTH-bit product if operand signs differ.
  - Signed divide: negate the quotient if signs differ; the remainder takes the sign of the dividend.
  - Commit hi/lo, busy<=0, done<=1, go to IDLE.
- Latency: result visible WIDTH+1 = 33 cycles after the start edge. busy high for exactly 33 cycles. done high for exactly 1 cycle after the commit edge, then 0.
- HI/LO are not modified until the FIX commit. They keep their previous values throughout RUN.
- Back-to-back: start may be accepted in the same cycle that done=1 (busy already 0).
- start while busy=1 is ignored, including MTHI/MTLO. Latched operands are unaffected by input changes during RUN.
- Divide by zero (srcB=0, DIV or DIVU): no fault. Runs the full 33 cycles, then hi=srcA (original signed value), lo=all ones.
- Signed overflow, DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0. This is the natural result of the magnitude algorithm; no special flag.
- Most-negative operand: the absolute value of 0x80000000 must be treated as unsigned 2^31. Internal magnitudes are WIDTH-bit unsigned, so no overflow occurs.
- Reset mid-operation: aborts immediately. busy=0, done=0, hi=lo=0. No partial results are committed.
- Timing relative to the register file: the register file writes on negedge. This block samples srcA/srcB on posedge, so operands written on the preceding negedge are seen.

Test Plan:
- MULTU srcA=0xFFFFFFFF, srcB=0xFFFFFFFF -> busy high 33 cycles, done pulse once; hi=0xFFFFFFFE, lo=0x00000001.
- MULT srcA=-344 (0xFFFFFEA8), srcB=3 -> hi=0xFFFFFFFF, lo=0xFFFFFBF8 (-1032). MULTU with the same operands -> hi=0x00000002, lo=0xFFFFFBF8.
- DIV srcA=-7, srcB=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 7/2 -> lo=3, hi=1. DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU 100/0 -> hi=0x00000064, lo=0xFFFFFFFF, done after 33 cycles.
- Handshake sequence:
  - MTLO 0x1234 in IDLE -> lo=0x1234 next edge, busy and done stay 0.
  - Start MULTU 5*6, then assert start with DIVU 9/3 at cycle 10 -> the second request is ignored; result is hi=0, lo=30.
  - New start issued during the done cycle -> accepted.
- Reset pulse asserted between edges at cycle 15 of a MULT (srcA=2, srcB=3) -> busy, done, hi and lo go to 0 asynchronously. No done pulse follows. A fresh MULT 2*3 after release -> lo=6, hi=0.

Source files
------------

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - multi-cycle MIPS multiply/divide unit with HI/LO registers
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  logic [1:0]         state_q,    state_d;
  logic [CW-1:0]      cnt_q,      cnt_d;
  logic               is_div_q,   is_div_d;
  logic               neg_res_q,  neg_res_d;   // negate product / quotient
  logic               neg_rem_q,  neg_rem_d;   // negate remainder
  logic               div_zero_q, div_zero_d;
  logic [WIDTH-1:0]   opnd_q,     opnd_d;      // multiplicand magnitude or divisor magnitude
  logic [WIDTH-1:0]   a_orig_q,   a_orig_d;    // raw dividend, needed for divide-by-zero result
  logic [2*WIDTH-1:0] acc_q,      acc_d;       // {partial product / remainder, multiplier / quotient}
  logic [WIDTH-1:0]   hi_q,       hi_d;
  logic [WIDTH-1:0]   lo_q,       lo_d;
  logic               done_q,     done_d;

  logic               is_signed;
  logic               is_arith;
  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     rem_sh;
  logic               div_ge;
  logic [WIDTH-1:0]   rem_diff;
  logic [WIDTH-1:0]   rem_next;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix;
  logic [WIDTH-1:0]   rem_fix;

  // Operand decode: magnitudes are WIDTH-bit unsigned, so |most-negative| is exact.
  always_comb begin
    is_signed = (op == OP_MULT) || (op == OP_DIV);
    is_arith  = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
    a_neg     = is_signed & srcA[WIDTH-1];
    b_neg     = is_signed & srcB[WIDTH-1];
    a_mag     = a_neg ? (~srcA + 1'b1) : srcA;
    b_mag     = b_neg ? (~srcB + 1'b1) : srcB;
  end

  // One shift-add multiply step and one restoring divide step, selected later by is_div_q.
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opnd_q & {WIDTH{acc_q[0]}}};
    rem_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_ge   = rem_sh >= {1'b0, opnd_q};
    rem_diff = rem_sh[WIDTH-1:0] - opnd_q;
    rem_next = div_ge ? rem_diff : rem_sh[WIDTH-1:0];
  end

  // Sign correction applied when committing results.
  always_comb begin
    prod_fix = neg_res_q ? (~acc_q + 1'b1) : acc_q;
    quot_fix = neg_res_q ? (~acc_q[WIDTH-1:0] + 1'b1) : acc_q[WIDTH-1:0];
    rem_fix  = neg_rem_q ? (~acc_q[2*WIDTH-1:WIDTH] + 1'b1) : acc_q[2*WIDTH-1:WIDTH];
  end

  // Next-state logic for the IDLE -> RUN -> FIX sequencer and HI/LO.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    is_div_d   = is_div_q;
    neg_res_d  = neg_res_q;
    neg_rem_d  = neg_rem_q;
    div_zero_d = div_zero_q;
    opnd_d     = opnd_q;
    a_orig_d   = a_orig_q;
    acc_d      = acc_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    done_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (is_arith) begin
            is_div_d   = (op == OP_DIV) || (op == OP_DIVU);
            div_zero_d = (srcB == '0);
            a_orig_d   = srcA;
            cnt_d      = '0;
            state_d    = ST_RUN;
            if ((op == OP_DIV) || (op == OP_DIVU)) begin
              neg_res_d = a_neg ^ b_neg;
              neg_rem_d = a_neg;
              opnd_d    = b_mag;
              acc_d     = {{WIDTH{1'b0}}, a_mag};
            end else begin
              neg_res_d = a_neg ^ b_neg;
              neg_rem_d = 1'b0;
              opnd_d    = a_mag;
              acc_d     = {{WIDTH{1'b0}}, b_mag};
            end
          end else if (op == OP_MTHI) begin
            hi_d = srcA;
          end else if (op == OP_MTLO) begin
            lo_d = srcA;
          end
        end
      end

      ST_RUN: begin
        if (is_div_q) begin
          acc_d = {rem_next, acc_q[WIDTH-2:0], div_ge};
        end else begin
          acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = ST_FIX;
        end
      end

      ST_FIX: begin
        if (!is_div_q) begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end else if (div_zero_q) begin
          hi_d = a_orig_q;
          lo_d = '1;
        end else begin
          hi_d = rem_fix;
          lo_d = quot_fix;
        end
        done_d  = 1'b1;
        cnt_d   = '0;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers; reset aborts any operation in flight.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      is_div_q   <= 1'b0;
      neg_res_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      div_zero_q <= 1'b0;
      opnd_q     <= '0;
      a_orig_q   <= '0;
      acc_q      <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      is_div_q   <= is_div_d;
      neg_res_q  <= neg_res_d;
      neg_rem_q  <= neg_rem_d;
      div_zero_q <= div_zero_d;
      opnd_q     <= opnd_d;
      a_orig_q   <= a_orig_d;
      acc_q      <= acc_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      done_q     <= done_d;
    end
  end

  assign busy = (state_q != ST_IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - self-checking bench for mult_div_unit
module tb_mult_div_unit;

  logic        Clk;
  logic        Reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] srcA;
  logic [31:0] srcB;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int total = 0;
  int bad   = 0;

  logic [31:0] m_hi, m_lo;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] eh;
    logic [31:0] el;
  } vec_t;

  vec_t tbl[11];

  mult_div_unit #(.WIDTH(32)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .start (start),
    .op    (op),
    .srcA  (srcA),
    .srcB  (srcB),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic following the MIPS HI/LO rules.
  task automatic ref_model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                           inout logic [31:0] rh, inout logic [31:0] rl);
    longint sa, sb, sq, sr;
    logic [63:0] p, qv, rv;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      3'd0: begin p = sa * sb; rh = p[63:32]; rl = p[31:0]; end
      3'd1: begin p = {32'd0, a} * {32'd0, b}; rh = p[63:32]; rl = p[31:0]; end
      3'd2, 3'd3: begin
        if (b == 32'd0) begin
          rh = a; rl = 32'hFFFF_FFFF;
        end else if (o == 3'd2) begin
          sq = sa / sb; sr = sa % sb; qv = sq; rv = sr;
          rh = rv[31:0]; rl = qv[31:0];
        end else begin
          rh = a % b; rl = a / b;
        end
      end
      3'd4: rh = a;
      3'd5: rl = a;
      default: ;
    endcase
  endtask

  // Issue an arithmetic op at the current negedge; returns at the negedge where done=1.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] rh, output logic [31:0] rl);
    logic [31:0] h0, l0;
    bit stable, seen;
    int bc;
    h0 = hi; l0 = lo; stable = 1; seen = 0; bc = 0;
    start = 1'b1; op = o; srcA = a; srcB = b;
    @(negedge Clk);
    start = 1'b0; srcA = $urandom; srcB = $urandom;
    for (int i = 0; i < 40; i++) begin
      if (done) begin
        seen = 1;
        break;
      end
      if (busy) bc++;
      if (hi !== h0 || lo !== l0) stable = 0;
      @(negedge Clk);
    end
    chk("done_seen", 64'(seen), 64'd1);
    chk("busy_cycles", 64'(bc), 64'd33);
    chk("hilo_hold_during_run", 64'(stable), 64'd1);
    rh = hi; rl = lo;
  endtask

  // Single-cycle start for MTHI/MTLO/reserved ops.
  task automatic short_op(input logic [2:0] o, input logic [31:0] a);
    start = 1'b1; op = o; srcA = a; srcB = $urandom;
    @(negedge Clk);
    start = 1'b0;
  endtask

  logic [31:0] rh, rl, eh, el, ra, rb;
  logic [2:0]  ro;
  bit          got;

  initial begin
    tbl[0]  = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    tbl[1]  = '{3'd0, 32'hFFFF_FEA8, 32'd3,         32'hFFFF_FFFF, 32'hFFFF_FBF8};
    tbl[2]  = '{3'd1, 32'hFFFF_FEA8, 32'd3,         32'h0000_0002, 32'hFFFF_FBF8};
    tbl[3]  = '{3'd2, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
    tbl[4]  = '{3'd3, 32'd7,         32'd2,         32'd1,         32'd3};
    tbl[5]  = '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000};
    tbl[6]  = '{3'd3, 32'd100,       32'd0,         32'h0000_0064, 32'hFFFF_FFFF};
    tbl[7]  = '{3'd2, 32'hFFFF_FF9C, 32'd0,         32'hFFFF_FF9C, 32'hFFFF_FFFF};
    tbl[8]  = '{3'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0};
    tbl[9]  = '{3'd2, 32'h8000_0000, 32'd2,         32'd0,         32'hC000_0000};
    tbl[10] = '{3'd2, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD};

    Reset = 1'b1; start = 1'b0; op = 3'd0; srcA = '0; srcB = '0;
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_hi", 64'(hi), 64'd0);
    chk("reset_lo", 64'(lo), 64'd0);

    // MTLO in IDLE
    short_op(3'd5, 32'h0000_1234);
    chk("mtlo_lo", 64'(lo), 64'h1234);
    chk("mtlo_hi", 64'(hi), 64'd0);
    chk("mtlo_busy", 64'(busy), 64'd0);
    chk("mtlo_done", 64'(done), 64'd0);

    // Directed vectors
    for (int i = 0; i < 11; i++) begin
      run_op(tbl[i].op, tbl[i].a, tbl[i].b, rh, rl);
      chk($sformatf("vec%0d_hi", i), 64'(rh), 64'(tbl[i].eh));
      chk($sformatf("vec%0d_lo", i), 64'(rl), 64'(tbl[i].el));
      @(negedge Clk);
      chk($sformatf("vec%0d_done_width", i), 64'(done), 64'd0);
    end

    // Start while busy is ignored
    start = 1'b1; op = 3'd1; srcA = 32'd5; srcB = 32'd6;
    @(negedge Clk);
    start = 1'b0;
    repeat (9) @(negedge Clk);
    start = 1'b1; op = 3'd3; srcA = 32'd9; srcB = 32'd3;
    @(negedge Clk);
    start = 1'b1; op = 3'd4; srcA = 32'hDEAD_BEEF;
    @(negedge Clk);
    start = 1'b0;
    got = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) begin got = 1; break; end
      @(negedge Clk);
    end
    chk("busy_ignore_done", 64'(got), 64'd1);
    chk("busy_ignore_hi", 64'(hi), 64'd0);
    chk("busy_ignore_lo", 64'(lo), 64'd30);

    // Back-to-back: second start issued in the done cycle
    @(negedge Clk);
    run_op(3'd1, 32'd7, 32'd8, rh, rl);
    chk("b2b_first_lo", 64'(rl), 64'd56);
    run_op(3'd3, 32'd100, 32'd7, rh, rl);
    chk("b2b_second_lo", 64'(rl), 64'd14);
    chk("b2b_second_hi", 64'(rh), 64'd2);
    @(negedge Clk);

    // Reserved op has no effect
    short_op(3'd6, 32'h5555_5555);
    chk("rsvd_busy", 64'(busy), 64'd0);
    chk("rsvd_hi", 64'(hi), 64'd2);
    chk("rsvd_lo", 64'(lo), 64'd14);

    // Randomized ops against the reference model
    m_hi = 32'hCAFE_0001; m_lo = 32'hF00D_0002;
    short_op(3'd4, m_hi);
    short_op(3'd5, m_lo);
    for (int n = 0; n < 40; n++) begin
      ro = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: ra = 32'h8000_0000;
        2: rb = 32'hFFFF_FFFF;
        3: rb = 32'($urandom_range(1, 20));
        default: ;
      endcase
      eh = m_hi; el = m_lo;
      ref_model(ro, ra, rb, eh, el);
      if (ro < 3'd4) begin
        run_op(ro, ra, rb, rh, rl);
        chk($sformatf("rnd%0d_op%0d_hi", n, ro), 64'(rh), 64'(eh));
        chk($sformatf("rnd%0d_op%0d_lo", n, ro), 64'(rl), 64'(el));
        @(negedge Clk);
      end else begin
        short_op(ro, ra);
        chk($sformatf("rnd%0d_op%0d_hi", n, ro), 64'(hi), 64'(eh));
        chk($sformatf("rnd%0d_op%0d_lo", n, ro), 64'(lo), 64'(el));
        chk($sformatf("rnd%0d_op%0d_busy", n, ro), 64'(busy), 64'd0);
      end
      m_hi = eh; m_lo = el;
    end

    // Reset in the middle of a MULT
    short_op(3'd5, 32'h0000_DEAD);
    short_op(3'd4, 32'h0000_BEEF);
    start = 1'b1; op = 3'd0; srcA = 32'd2; srcB = 32'd3;
    @(negedge Clk);
    start = 1'b0;
    repeat (14) @(negedge Clk);
    chk("pre_reset_busy", 64'(busy), 64'd1);
    #2 Reset = 1'b1;
    #1;
    chk("async_rst_busy", 64'(busy), 64'd0);
    chk("async_rst_done", 64'(done), 64'd0);
    chk("async_rst_hi", 64'(hi), 64'd0);
    chk("async_rst_lo", 64'(lo), 64'd0);
    @(negedge Clk);
    Reset = 1'b0;
    got = 0;
    for (int i = 0; i < 40; i++) begin
      if (done || busy) got = 1;
      @(negedge Clk);
    end
    chk("no_done_after_reset", 64'(got), 64'd0);
    run_op(3'd0, 32'd2, 32'd3, rh, rl);
    chk("post_reset_lo", 64'(rl), 64'd6);
    chk("post_reset_hi", 64'(rh), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
